// File: rtl/dmi_req_buffer_if.sv
// One DMI link: request channel toward the debug module, response channel back.
// The master drives requests and accepts responses; the slave does the reverse.
interface dmi_req_buffer_if #(
   parameter int ADDR_BITS = 7
);
   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_BITS-1:0] req_bits_addr;
   logic [1:0]           req_bits_op;
   logic [31:0]          req_bits_data;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [1:0]           resp_bits_resp;
   logic [31:0]          resp_bits_data;

   modport master (
      output req_valid, req_bits_addr, req_bits_op, req_bits_data,
      input  req_ready,
      input  resp_valid, resp_bits_resp, resp_bits_data,
      output resp_ready
   );

   modport slave (
      input  req_valid, req_bits_addr, req_bits_op, req_bits_data,
      output req_ready,
      output resp_valid, resp_bits_resp, resp_bits_data,
      input  resp_ready
   );
endinterface

// File: rtl/dmi_req_buffer.sv
// DMI request FIFO with an in-flight limit, an in-order registered response stage,
// and local rejection of reserved ops (answered with resp=2, never forwarded).
module dmi_req_buffer #(
   parameter  int DEPTH           = 4,
   parameter  int ADDR_BITS       = 7,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   dmi_req_buffer_if.slave        up,
   dmi_req_buffer_if.master       dn,
   output logic [OW-1:0]          outstanding,
   output logic [7:0]             err_count
);
   localparam int            PW     = $clog2(DEPTH);
   localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
   localparam logic [1:0]    OP_RSV = 2'd3;
   localparam logic [1:0]    RSP_FAIL = 2'd2;

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [1:0]           op;
      logic [31:0]          data;
   } req_t;

   req_t          mem [DEPTH];
   req_t          head;
   logic [PW:0]   wr_ptr, rd_ptr;
   logic          full, empty;
   logic          push, pop, dn_fire, dn_resp_fire, rej, resp_free;

   logic          resp_vld;
   logic [1:0]    resp_code;
   logic [31:0]   resp_data;

   // Wrap bit differs and index matches -> full; identical pointers -> empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   // Depends only on state and reset, never on dn.req_ready.
   assign up.req_ready = reset && !full;
   assign push         = up.req_valid && up.req_ready;

   assign dn.req_valid     = !empty && (head.op != OP_RSV) && (outstanding < MAX_OS);
   assign dn.req_bits_addr = head.addr;
   assign dn.req_bits_op   = head.op;
   assign dn.req_bits_data = head.data;
   assign dn_fire          = dn.req_valid && dn.req_ready;

   assign resp_free    = !resp_vld || up.resp_ready;
   assign dn.resp_ready = (outstanding != '0) && resp_free;
   assign dn_resp_fire = dn.resp_valid && dn.resp_ready;

   // A reserved op waits until everything older has answered, which keeps order
   // and guarantees the response register is not also loaded from downstream.
   assign rej = !empty && (head.op == OP_RSV) && (outstanding == '0) && resp_free;
   assign pop = dn_fire || rej;

   assign up.resp_valid     = resp_vld;
   assign up.resp_bits_resp = resp_code;
   assign up.resp_bits_data = resp_data;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PW-1:0]] <= '{addr: up.req_bits_addr, op: up.req_bits_op,
                                  data: up.req_bits_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         resp_vld  <= 1'b0;
         resp_code <= '0;
         resp_data <= '0;
      end else if (dn_resp_fire) begin
         resp_vld  <= 1'b1;
         resp_code <= dn.resp_bits_resp;
         resp_data <= dn.resp_bits_data;
      end else if (rej) begin
         resp_vld  <= 1'b1;
         resp_code <= RSP_FAIL;
         resp_data <= '0;
      end else if (up.resp_ready) begin
         resp_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         outstanding <= '0;
      end else begin
         case ({dn_fire, dn_resp_fire})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_count <= '0;
      end else if (rej && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

   a_os_bound: assert property (@(posedge clk) disable iff (!reset) outstanding <= MAX_OS);
   a_no_collide: assert property (@(posedge clk) disable iff (!reset) !(rej && dn_resp_fire));
endmodule

// File: tb/tb_dmi_req_buffer.sv
// Directed bench for dmi_req_buffer with hand-computed expectations.
module tb_dmi_req_buffer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] outstanding;
   logic [7:0] err_count;
   int         checks = 0;
   int         failures = 0;
   bit         saw_rsvd = 1'b0;

   dmi_req_buffer_if #(.ADDR_BITS(7)) up_if ();
   dmi_req_buffer_if #(.ADDR_BITS(7)) dn_if ();

   dmi_req_buffer #(.DEPTH(4), .ADDR_BITS(7), .MAX_OUTSTANDING(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .up          (up_if),
      .dn          (dn_if),
      .outstanding (outstanding),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (reset && dn_if.req_valid && dn_if.req_bits_op == 2'd3) saw_rsvd <= 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
      bit done = 1'b0;
      up_if.req_valid = 1'b1;
      up_if.req_bits_addr = a;
      up_if.req_bits_op = op;
      up_if.req_bits_data = d;
      for (int k = 0; k < 20 && !done; k++) begin
         if (up_if.req_ready) done = 1'b1;
         tick();
      end
      up_if.req_valid = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   initial begin
      up_if.req_valid = 0; up_if.req_bits_addr = 0; up_if.req_bits_op = 0; up_if.req_bits_data = 0;
      up_if.resp_ready = 0;
      dn_if.req_ready = 0; dn_if.resp_valid = 0; dn_if.resp_bits_resp = 0; dn_if.resp_bits_data = 0;

      // reset state
      tick(); tick();
      chk("rst_up_rdy", up_if.req_ready, 0);
      chk("rst_up_rsp_v", up_if.resp_valid, 0);
      chk("rst_dn_v", dn_if.req_valid, 0);
      chk("rst_dn_rsp_rdy", dn_if.resp_ready, 0);
      chk("rst_os", outstanding, 0);
      chk("rst_err", err_count, 0);
      reset = 1'b1;
      #1 chk("rel_up_rdy", up_if.req_ready, 1);

      // single read
      up_if.req_valid = 1; up_if.req_bits_addr = 7'h11; up_if.req_bits_op = 1; up_if.req_bits_data = 0;
      #1 chk("t1_nobypass", dn_if.req_valid, 0);
      tick(); up_if.req_valid = 0;
      chk("t1_dn_v", dn_if.req_valid, 1);
      chk("t1_dn_addr", dn_if.req_bits_addr, 7'h11);
      chk("t1_dn_op", dn_if.req_bits_op, 1);
      dn_if.req_ready = 1; tick(); dn_if.req_ready = 0;
      chk("t1_os1", outstanding, 1);
      chk("t1_dn_v0", dn_if.req_valid, 0);
      up_if.resp_ready = 1;
      dn_if.resp_valid = 1; dn_if.resp_bits_resp = 0; dn_if.resp_bits_data = 32'hDEADBEEF;
      #1 chk("t1_dn_rsp_rdy", dn_if.resp_ready, 1);
      tick(); dn_if.resp_valid = 0;
      chk("t1_rsp_v", up_if.resp_valid, 1);
      chk("t1_rsp_code", up_if.resp_bits_resp, 0);
      chk("t1_rsp_data", up_if.resp_bits_data, 32'hDEADBEEF);
      chk("t1_os0", outstanding, 0);
      tick();
      chk("t1_rsp_drained", up_if.resp_valid, 0);

      // FIFO full, drain in order, then wrap
      for (int i = 0; i < 5; i++) begin
         up_if.req_valid = 1; up_if.req_bits_addr = 7'(8'h20 + i); up_if.req_bits_op = 2;
         up_if.req_bits_data = 32'h100 + i;
         #1 chk("t2_up_rdy", up_if.req_ready, (i < 4) ? 1 : 0);
         tick();
      end
      up_if.req_valid = 0;
      dn_if.req_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t2_dn_v", dn_if.req_valid, 1);
         chk("t2_dn_addr", dn_if.req_bits_addr, 32'h20 + i);
         chk("t2_dn_data", dn_if.req_bits_data, 32'h100 + i);
         tick();
      end
      dn_if.req_ready = 0;
      chk("t2_os4", outstanding, 4);
      for (int i = 0; i < 4; i++) begin
         dn_if.resp_valid = 1; dn_if.resp_bits_resp = 0; dn_if.resp_bits_data = 32'hA0 + i;
         #1 chk("t2_dn_rsp_rdy", dn_if.resp_ready, 1);
         tick();
         chk("t2_rsp_data", up_if.resp_bits_data, 32'hA0 + i);
      end
      dn_if.resp_valid = 0;
      tick();
      chk("t2_os0", outstanding, 0);
      chk("t2_rsp_v0", up_if.resp_valid, 0);
      up_if.req_valid = 1; up_if.req_bits_addr = 7'h24; up_if.req_bits_op = 2; up_if.req_bits_data = 32'h104;
      #1 chk("t2_wrap_rdy", up_if.req_ready, 1);
      tick(); up_if.req_valid = 0;
      chk("t2_wrap_v", dn_if.req_valid, 1);
      chk("t2_wrap_addr", dn_if.req_bits_addr, 7'h24);
      dn_if.req_ready = 1; tick(); dn_if.req_ready = 0;
      chk("t2_wrap_os", outstanding, 1);
      dn_if.resp_valid = 1; dn_if.resp_bits_data = 0;
      tick(); dn_if.resp_valid = 0;
      tick();
      chk("t2_end_os", outstanding, 0);

      // outstanding limit
      dn_if.req_ready = 1;
      for (int i = 0; i < 6; i++) push(7'(8'h30 + i), 1, 0);
      repeat (4) tick();
      chk("t3_os4", outstanding, 4);
      chk("t3_dn_v0", dn_if.req_valid, 0);
      dn_if.resp_valid = 1; dn_if.resp_bits_data = 32'h31;
      tick(); dn_if.resp_valid = 0;
      chk("t3_os3", outstanding, 3);
      chk("t3_dn_v1", dn_if.req_valid, 1);
      chk("t3_dn_addr", dn_if.req_bits_addr, 7'h34);
      tick();
      chk("t3_os4b", outstanding, 4);
      chk("t3_dn_v0b", dn_if.req_valid, 0);
      dn_if.resp_valid = 1;
      repeat (8) tick();
      chk("t3_drain_os", outstanding, 0);
      chk("t3_zero_rdy", dn_if.resp_ready, 0);
      dn_if.resp_valid = 0; dn_if.req_ready = 0;
      tick();
      chk("t3_rsp_v0", up_if.resp_valid, 0);

      // reserved op stays behind older responses
      dn_if.req_ready = 1;
      push(7'h40, 2, 32'h111);
      push(7'h41, 2, 32'h222);
      push(7'h42, 3, 32'h333);
      repeat (5) tick();
      chk("t4_os2", outstanding, 2);
      chk("t4_err0", err_count, 0);
      chk("t4_rsp_v0", up_if.resp_valid, 0);
      chk("t4_dn_v0", dn_if.req_valid, 0);
      dn_if.resp_valid = 1; dn_if.resp_bits_resp = 0; dn_if.resp_bits_data = 32'h51;
      tick();
      chk("t4_r1_data", up_if.resp_bits_data, 32'h51);
      chk("t4_r1_code", up_if.resp_bits_resp, 0);
      dn_if.resp_bits_data = 32'h52;
      tick(); dn_if.resp_valid = 0;
      chk("t4_r2_data", up_if.resp_bits_data, 32'h52);
      chk("t4_r2_code", up_if.resp_bits_resp, 0);
      tick();
      chk("t4_r3_v", up_if.resp_valid, 1);
      chk("t4_r3_code", up_if.resp_bits_resp, 2);
      chk("t4_r3_data", up_if.resp_bits_data, 0);
      chk("t4_err1", err_count, 1);
      tick();
      chk("t4_rsp_v0b", up_if.resp_valid, 0);
      chk("t4_os0", outstanding, 0);
      chk("t4_never_fwd", saw_rsvd, 0);

      // response backpressure
      up_if.resp_ready = 0;
      push(7'h60, 1, 0);
      push(7'h61, 1, 0);
      tick(); tick();
      dn_if.req_ready = 0;
      chk("t5_os2", outstanding, 2);
      dn_if.resp_valid = 1; dn_if.resp_bits_resp = 0; dn_if.resp_bits_data = 32'h71;
      #1 chk("t5_rdy1", dn_if.resp_ready, 1);
      tick();
      chk("t5_r1_v", up_if.resp_valid, 1);
      chk("t5_r1_data", up_if.resp_bits_data, 32'h71);
      dn_if.resp_bits_data = 32'h72;
      #1 chk("t5_rdy_blocked", dn_if.resp_ready, 0);
      tick();
      chk("t5_hold_data", up_if.resp_bits_data, 32'h71);
      chk("t5_os1", outstanding, 1);
      up_if.resp_ready = 1;
      #1 chk("t5_rdy_pass", dn_if.resp_ready, 1);
      tick(); dn_if.resp_valid = 0;
      chk("t5_r2_v", up_if.resp_valid, 1);
      chk("t5_r2_data", up_if.resp_bits_data, 32'h72);
      chk("t5_os0", outstanding, 0);
      tick();
      chk("t5_rsp_v0", up_if.resp_valid, 0);

      // err_count saturation
      for (int i = 0; i < 260; i++) push(7'h7F, 3, 0);
      repeat (3) tick();
      chk("t6_err_sat", err_count, 255);
      chk("t6_os0", outstanding, 0);
      chk("t6_rsp_v0", up_if.resp_valid, 0);
      chk("t6_never_fwd", saw_rsvd, 0);

      // reset mid-operation
      dn_if.req_ready = 1;
      push(7'h01, 1, 0);
      push(7'h02, 1, 0);
      tick(); tick();
      dn_if.req_ready = 0;
      chk("t7_os2", outstanding, 2);
      push(7'h03, 2, 1);
      push(7'h04, 2, 2);
      push(7'h05, 2, 3);
      chk("t7_dn_v", dn_if.req_valid, 1);
      reset = 1'b0;
      tick();
      chk("t7_rsp_v0", up_if.resp_valid, 0);
      chk("t7_dn_v0", dn_if.req_valid, 0);
      chk("t7_os0", outstanding, 0);
      chk("t7_err0", err_count, 0);
      chk("t7_up_rdy_rst", up_if.req_ready, 0);
      reset = 1'b1;
      #1 chk("t7_up_rdy", up_if.req_ready, 1);
      chk("t7_dn_v0b", dn_if.req_valid, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmi_req_buffer.md
Name: dmi_req_buffer

Overview:
- Sits directly downstream of the simulation debug transport module, between its DMI request/response ports and the debug module's DMI slave port.
- Buffers DMI requests in a FIFO and bounds the number of in-flight requests.
- Returns responses in order through a registered response stage.
- Rejects reserved-op requests locally, with an in-order error response, and never forwards them.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, >=2)
- ADDR_BITS, 7, DMI address width
- MAX_OUTSTANDING, 4, max requests issued downstream without a response (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- up_req_valid  in  1  request from transport
- up_req_ready  out  1  request accepted
- up_req_bits_addr  in  ADDR_BITS  DMI address
- up_req_bits_op  in  2  0=nop, 1=read, 2=write, 3=reserved
- up_req_bits_data  in  32  write data
- up_resp_valid  out  1  response to transport
- up_resp_ready  in  1  transport accepts response
- up_resp_bits_resp  out  2  0=ok, 2=failed, 3=busy
- up_resp_bits_data  out  32  read data
- dn_req_valid / dn_req_ready / dn_req_bits_addr / dn_req_bits_op / dn_req_bits_data  out/in/out/out/out  1/1/ADDR_BITS/2/32  request to debug module
- dn_resp_valid / dn_resp_ready / dn_resp_bits_resp / dn_resp_bits_data  in/out/in/in  1/1/2/32  response from debug module
- outstanding  out  clog2(MAX_OUTSTANDING+1)  in-flight downstream count
- err_count  out  8  saturating count of locally rejected ops

Behaviour:
- Reset (reset==0 sampled at posedge clk):
  - FIFO emptied; outstanding=0; err_count=0; response register invalid with resp=0, data=0.
  - Outputs during and after reset: up_req_ready=0 while reset==0, then 1 (FIFO empty); up_resp_valid=0; dn_req_valid=0; dn_resp_ready=0.
- Reset mid-operation drops all queued, in-flight and held responses. The debug module shares this reset, so no stale responses are expected.
- Request FIFO:
  - up_req_ready = !full. Registered only; no combinational path from dn_req_ready.
  - When full, up_req_ready=0 even on a dequeue cycle.
  - Enqueue and dequeue in the same cycle are allowed when not full.
  - No bypass: a request accepted at cycle N is visible at the head at N+1 at the earliest.
  - Pointers are log2(DEPTH) bits plus a wrap bit; full/empty come from pointer compare, including across wrap-around.
- Downstream issue:
  - dn_req_valid = !empty && head_op!=3 && outstanding<MAX_OUTSTANDING.
  - dn_req_bits are driven from the FIFO head storage.
  - Fire (valid&&ready) pops the head and increments outstanding.
  - Nop (op 0) is forwarded like read/write.
- Response path:
  - Single holding register drives up_resp_*.
  - dn_resp_ready = (outstanding!=0) && (!up_resp_valid || up_resp_ready). The combinational pass-through of up_resp_ready is intended.
  - dn_resp fire loads the register with resp/data unchanged and decrements outstanding.
  - dn_req fire and dn_resp fire in the same cycle leave outstanding unchanged.
  - A dn_resp_valid while outstanding==0 is not accepted (ready=0).
  - Throughput: 1 response/cycle when up_resp_ready is held high.
- Local rejection (head_op==3):
  - Trigger: outstanding==0 and the response register is free or being drained this cycle.
  - Action: pop head, load register with resp=2, data=0, and set err_count=min(err_count+1,255).
  - The block stalls while older requests are outstanding, so the error response is never reordered ahead of earlier responses.
  - Since outstanding==0, no dn_resp can collide in that cycle.
- Arithmetic:
  - outstanding never exceeds MAX_OUTSTANDING and never underflows.
  - err_count saturates at 255 and is held there.

Test Plan:
- Single read: up_req addr=0x11 op=1 at cycle N -> dn_req_valid at N+1 with addr 0x11. dn_resp resp=0 data=0xDEADBEEF -> up_resp_valid next cycle with same values; outstanding returns 0.
- FIFO full: dn_req_ready=0, push 5 writes -> 4 accepted, up_req_ready=0 on 5th. Release dn_req_ready -> 4 requests in order at 1/cycle. Push the 5th afterward -> accepted; verifies wrap-around.
- Outstanding limit: dn_req_ready=1, dn_resp_valid=0, queue 6 reads -> exactly 4 issued, dn_req_valid drops, outstanding=4. Return one response -> 5th issued next cycle.
- Reserved op ordering: write, write, op=3 queued; delay both dn_resp by 5 cycles -> up_resp order ok, ok, then resp=2 data=0. op=3 never on dn_req; err_count=1.
- Backpressure: up_resp_ready=0, two dn_resp offered -> first latched, dn_resp_ready=0 for second. Raise up_resp_ready -> second passes next cycle, no loss or duplication.
- Reset mid-op: 3 queued, 2 outstanding, reset=0 one cycle -> next cycle up_resp_valid=0, dn_req_valid=0, outstanding=0, err_count=0, up_req_ready=1 after release.
